// File: rtl/dmi_reg_responder.sv
// DMI responder: scratch register bank, ID word and write counter behind an in-order response FIFO.
// Optional build macro DMI_RSP_STICKY_ERR_EN adds a sticky error bit at 7'h13.
module dmi_reg_responder #(
    parameter int unsigned NUM_REGS  = 8,
    parameter logic [6:0]  BASE_ADDR = 7'h04,
    parameter logic [6:0]  ID_ADDR   = 7'h11,
    parameter logic [31:0] ID_VALUE  = 32'h0000_0C82,
    parameter logic [6:0]  CNT_ADDR  = 7'h12,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  dmi_req_valid,
    output logic                  dmi_req_ready,
    input  logic [6:0]            dmi_req_addr,
    input  logic [31:0]           dmi_req_data,
    input  logic [1:0]            dmi_req_op,
    output logic                  dmi_rsp_valid,
    input  logic                  dmi_rsp_ready,
    output logic [31:0]           dmi_rsp_data,
    output logic [1:0]            dmi_rsp_response,
    output logic [NUM_REGS*32-1:0] regs_out
);

    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam logic [1:0] OP_NOP = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2;
    localparam logic [1:0] RSP_OK = 2'd0, RSP_FAIL = 2'd2;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t          fifo_q [RSP_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   scratch_q [NUM_REGS];
    logic [31:0]   cnt_q;

    logic          accept, pop, scr_hit, do_wr;
    logic [6:0]    addr_off;
    logic [31:0]   scr_rd;
    rsp_t          rsp_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign dmi_req_ready    = !RST && (count_q < CW'(RSP_DEPTH));
    assign accept           = dmi_req_valid && dmi_req_ready;
    assign dmi_rsp_valid    = (count_q != '0);
    assign pop              = dmi_rsp_valid && dmi_rsp_ready;
    assign dmi_rsp_data     = dmi_rsp_valid ? fifo_q[rd_ptr_q].data : 32'd0;
    assign dmi_rsp_response = dmi_rsp_valid ? fifo_q[rd_ptr_q].resp : RSP_OK;

    // 8-bit upper bound so a window ending near 7'h7F never wraps
    assign addr_off = dmi_req_addr - BASE_ADDR;
    assign scr_hit  = (dmi_req_addr >= BASE_ADDR) &&
                      ({1'b0, dmi_req_addr} < ({1'b0, BASE_ADDR} + 8'(NUM_REGS)));

    always_comb begin
        scr_rd = 32'd0;
        for (int i = 0; i < NUM_REGS; i++)
            if (addr_off == 7'(i)) scr_rd = scratch_q[i];
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[32*g +: 32] = scratch_q[g];
    end

`ifdef DMI_RSP_STICKY_ERR_EN
    localparam logic [6:0] STICKY_ADDR = 7'h13;
    logic sticky_q, sticky_clr;

    assign sticky_clr = (dmi_req_op == OP_WR) && (dmi_req_addr == STICKY_ADDR) && dmi_req_data[0];
`endif

    always_comb begin
        rsp_d = '{data: 32'd0, resp: RSP_OK};
        do_wr = 1'b0;
        case (dmi_req_op)
            OP_NOP: ;
            OP_RD: begin
                if (scr_hit)                     rsp_d.data = scr_rd;
                else if (dmi_req_addr == ID_ADDR)  rsp_d.data = ID_VALUE;
                else if (dmi_req_addr == CNT_ADDR) rsp_d.data = cnt_q;
`ifdef DMI_RSP_STICKY_ERR_EN
                else if (dmi_req_addr == STICKY_ADDR) rsp_d.data = {31'd0, sticky_q};
`endif
                else                             rsp_d.resp = RSP_FAIL;
            end
            OP_WR: begin
                if (scr_hit) do_wr = 1'b1;
`ifdef DMI_RSP_STICKY_ERR_EN
                else if (dmi_req_addr == STICKY_ADDR) ;
`endif
                else rsp_d.resp = RSP_FAIL;
            end
            default: rsp_d.resp = RSP_FAIL;
        endcase
`ifdef DMI_RSP_STICKY_ERR_EN
        // Once an error is latched, only the clearing write gets through
        if (sticky_q && !sticky_clr) begin
            rsp_d = '{data: 32'd0, resp: RSP_FAIL};
            do_wr = 1'b0;
        end
`endif
    end

    always_comb begin
        count_d = count_q;
        if (accept && !pop)      count_d = count_q + 1'b1;
        else if (!accept && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int j = 0; j < RSP_DEPTH; j++) fifo_q[j] <= '0;
            for (int i = 0; i < NUM_REGS; i++)  scratch_q[i] <= '0;
        end else begin
            count_q <= count_d;
            if (accept) begin
                fifo_q[wr_ptr_q] <= rsp_d;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (accept && do_wr) begin
                for (int i = 0; i < NUM_REGS; i++)
                    if (addr_off == 7'(i)) scratch_q[i] <= dmi_req_data;
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

`ifdef DMI_RSP_STICKY_ERR_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)             sticky_q <= 1'b0;
        else if (accept) begin
            if (sticky_clr)  sticky_q <= 1'b0;
            else if (rsp_d.resp == RSP_FAIL) sticky_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dmi_reg_responder.sv
// Directed bench for dmi_reg_responder; expected values are hand-derived constants.
module tb_dmi_reg_responder;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         dmi_req_valid = 1'b0;
    logic         dmi_req_ready;
    logic [6:0]   dmi_req_addr = '0;
    logic [31:0]  dmi_req_data = '0;
    logic [1:0]   dmi_req_op = '0;
    logic         dmi_rsp_valid;
    logic         dmi_rsp_ready = 1'b1;
    logic [31:0]  dmi_rsp_data;
    logic [1:0]   dmi_rsp_response;
    logic [255:0] regs_out;

    int errs = 0;
    int chks = 0;

    dmi_reg_responder dut (
        .CLK(CLK), .RST(RST),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
        .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_response(dmi_rsp_response),
        .regs_out(regs_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Called #1 after an edge with an empty FIFO and rsp_ready=1.
    task automatic req(input string tag, input logic [1:0] op, input logic [6:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d, input logic [1:0] exp_r);
        int n = 0;
        dmi_req_valid = 1'b1; dmi_req_op = op; dmi_req_addr = a; dmi_req_data = d;
        while (!dmi_req_ready && n < 20) begin tick(); n++; end
        if (n == 20) chk({tag, "_acc_timeout"}, 32'd0, 32'd1);
        tick();
        dmi_req_valid = 1'b0;
        chk({tag, "_vld"},  {31'd0, dmi_rsp_valid}, 32'd1);
        chk({tag, "_data"}, dmi_rsp_data, exp_d);
        chk({tag, "_resp"}, {30'd0, dmi_rsp_response}, {30'd0, exp_r});
        tick();
    endtask

    task automatic clr_sticky;
`ifdef DMI_RSP_STICKY_ERR_EN
        req("clr", 2'd2, 7'h13, 32'd1, 32'd0, 2'd0);
`endif
    endtask

    // Push one request with rsp_ready held low; must be accepted on the next edge.
    task automatic push(input string tag, input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
        dmi_req_valid = 1'b1; dmi_req_op = op; dmi_req_addr = a; dmi_req_data = d;
        chk({tag, "_rdy"}, {31'd0, dmi_req_ready}, 32'd1);
        tick();
        dmi_req_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_req_rdy", {31'd0, dmi_req_ready}, 32'd0);
        chk("rst_rsp_vld", {31'd0, dmi_rsp_valid}, 32'd0);
        chk("rst_rsp_data", dmi_rsp_data, 32'd0);
        chk("rst_rsp_resp", {30'd0, dmi_rsp_response}, 32'd0);
        chk("rst_regs", {31'd0, regs_out == '0}, 32'd1);
        tick(); tick();
        RST = 1'b0;
        tick();
        chk("post_rst_rdy", {31'd0, dmi_req_ready}, 32'd1);

        // Basic write/read/counter
        req("wr05", 2'd2, 7'h05, 32'hDEADBEEF, 32'd0, 2'd0);
        chk("regs05", regs_out[63:32], 32'hDEADBEEF);
        req("rd05", 2'd1, 7'h05, 32'd0, 32'hDEADBEEF, 2'd0);
        req("rdcnt1", 2'd1, 7'h12, 32'd0, 32'd1, 2'd0);
        req("rdid", 2'd1, 7'h11, 32'd0, 32'h0000_0C82, 2'd0);
        req("nop", 2'd0, 7'h05, 32'd0, 32'd0, 2'd0);
        req("rd0b", 2'd1, 7'h0B, 32'd0, 32'd0, 2'd0);

        // Failures, each followed by a sticky clear when that feature is built
        req("wrid", 2'd2, 7'h11, 32'h1234, 32'd0, 2'd2); clr_sticky();
        req("rdcnt_after_wrid", 2'd1, 7'h12, 32'd0, 32'd1, 2'd0);
        req("rd40", 2'd1, 7'h40, 32'd0, 32'd0, 2'd2); clr_sticky();
        req("op3", 2'd3, 7'h05, 32'd0, 32'd0, 2'd2); clr_sticky();
        req("rd0c", 2'd1, 7'h0C, 32'd0, 32'd0, 2'd2); clr_sticky();
        req("rd03", 2'd1, 7'h03, 32'd0, 32'd0, 2'd2); clr_sticky();
        req("wr0c", 2'd2, 7'h0C, 32'h55, 32'd0, 2'd2); clr_sticky();
`ifdef DMI_RSP_STICKY_ERR_EN
        req("rd13", 2'd1, 7'h13, 32'd0, 32'd0, 2'd0);
`else
        req("rd13", 2'd1, 7'h13, 32'd0, 32'd0, 2'd2);
`endif

        // Error followed by a scratch write
        req("rd40b", 2'd1, 7'h40, 32'd0, 32'd0, 2'd2);
`ifdef DMI_RSP_STICKY_ERR_EN
        req("wr04_blk", 2'd2, 7'h04, 32'd7, 32'd0, 2'd2);
        chk("regs04_blk", regs_out[31:0], 32'd0);
        req("rd13_set", 2'd1, 7'h13, 32'd0, 32'd0, 2'd2);
        req("wr13", 2'd2, 7'h13, 32'd1, 32'd0, 2'd0);
        req("wr04", 2'd2, 7'h04, 32'd7, 32'd0, 2'd0);
`else
        req("wr04", 2'd2, 7'h04, 32'd7, 32'd0, 2'd0);
`endif
        chk("regs04", regs_out[31:0], 32'd7);
        req("rdcnt2", 2'd1, 7'h12, 32'd0, 32'd2, 2'd0);

        // Backpressure: two fit, third waits for the first pop
        dmi_rsp_ready = 1'b0;
        push("bp0", 2'd1, 7'h05, 32'd0);
        push("bp1", 2'd1, 7'h11, 32'd0);
        dmi_req_valid = 1'b1; dmi_req_op = 2'd1; dmi_req_addr = 7'h12;
        chk("bp_full_rdy", {31'd0, dmi_req_ready}, 32'd0);
        chk("bp_head0", dmi_rsp_data, 32'hDEADBEEF);
        tick(); tick();
        chk("bp_full_rdy2", {31'd0, dmi_req_ready}, 32'd0);
        chk("bp_hold", dmi_rsp_data, 32'hDEADBEEF);
        dmi_rsp_ready = 1'b1;
        tick();
        chk("bp_head1", dmi_rsp_data, 32'h0000_0C82);
        chk("bp_rdy_after_pop", {31'd0, dmi_req_ready}, 32'd1);
        tick();
        dmi_req_valid = 1'b0;
        chk("bp_head2_vld", {31'd0, dmi_rsp_valid}, 32'd1);
        chk("bp_head2", dmi_rsp_data, 32'd2);
        tick();
        chk("bp_empty", {31'd0, dmi_rsp_valid}, 32'd0);

        // Read data is captured at accept, not at pop
        dmi_rsp_ready = 1'b0;
        push("st_rd", 2'd1, 7'h06, 32'd0);
        push("st_wr", 2'd2, 7'h06, 32'd1);
        chk("st_reg", regs_out[95:64], 32'd1);
        chk("st_rd_data", dmi_rsp_data, 32'd0);
        chk("st_rd_resp", {30'd0, dmi_rsp_response}, 32'd0);
        dmi_rsp_ready = 1'b1;
        tick();
        chk("st_wr_vld", {31'd0, dmi_rsp_valid}, 32'd1);
        tick();
        chk("st_empty", {31'd0, dmi_rsp_valid}, 32'd0);
        req("rdcnt3", 2'd1, 7'h12, 32'd0, 32'd3, 2'd0);

        // Reset with two responses queued
        dmi_rsp_ready = 1'b0;
        push("rb0", 2'd1, 7'h05, 32'd0);
        push("rb1", 2'd1, 7'h11, 32'd0);
        chk("rb_vld", {31'd0, dmi_rsp_valid}, 32'd1);
        RST = 1'b1;
        #1;
        chk("rb_rst_vld", {31'd0, dmi_rsp_valid}, 32'd0);
        chk("rb_rst_rdy", {31'd0, dmi_req_ready}, 32'd0);
        chk("rb_rst_regs", {31'd0, regs_out == '0}, 32'd1);
        tick();
        RST = 1'b0;
        dmi_rsp_ready = 1'b1;
        tick();
        req("rdcnt_rst", 2'd1, 7'h12, 32'd0, 32'd0, 2'd0);
        req("rd05_rst", 2'd1, 7'h05, 32'd0, 32'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
